// File: rtl/median_sort_pipe_if.sv
// Handshake bundle for median_sort_pipe: input vector channel and sorted output channel.
// The slave modport is the sorter's view; master is the producer/consumer side.
interface median_sort_pipe_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] data_in;
   logic               out_valid;
   logic               out_ready;
   logic [N*WIDTH-1:0] sort_out;
   logic [WIDTH-1:0]   median_out;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, sort_out, median_out
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, sort_out, median_out
   );
endinterface

// File: rtl/median_sort_pipe.sv
// Pipelined Batcher odd-even merge sorter for N lanes, one register stage per comparator layer.
// The whole pipe advances together; a stalled output freezes every stage.
module median_sort_pipe #(
   parameter int WIDTH  = 32,
   parameter int N      = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   median_sort_pipe_if.slave bus
);

   localparam int LOG_N = (N == 8) ? 3 : (N == 4) ? 2 : 1;
   localparam int S     = LOG_N * (LOG_N + 1) / 2;

   if (!(N == 2 || N == 4 || N == 8)) begin : g_bad_n
      $error("median_sort_pipe: N must be 2, 4 or 8");
   end

   // Lane paired with `lane` in comparator layer `layer`; returns `lane` when it passes through.
   function automatic int partner(input int lanes, input int layer, input int lane);
      int p;
      p = lane;
      if (lanes == 2 || layer == 0) begin
         p = lane ^ 1;
      end else if (layer == 1) begin
         p = lane ^ 2;
      end else if (lanes == 4 || layer == 2) begin
         case (lane)
            1: p = 2;
            2: p = 1;
            5: p = 6;
            6: p = 5;
            default: p = lane;
         endcase
      end else if (layer == 3) begin
         p = lane ^ 4;
      end else if (layer == 4) begin
         case (lane)
            2: p = 4;
            4: p = 2;
            3: p = 5;
            5: p = 3;
            default: p = lane;
         endcase
      end else begin
         case (lane)
            1: p = 2;
            2: p = 1;
            3: p = 4;
            4: p = 3;
            5: p = 6;
            6: p = 5;
            default: p = lane;
         endcase
      end
      return p;
   endfunction

   logic [WIDTH-1:0] stage_q [S][N];
   logic [WIDTH-1:0] stage_d [S][N];
   logic [S-1:0]     valid_q;
   logic             advance;

   assign advance      = !valid_q[S-1] || bus.out_ready;
   assign bus.in_ready = advance;

   for (genvar s = 0; s < S; s++) begin : g_stage
      for (genvar k = 0; k < N; k++) begin : g_lane
         localparam int P  = partner(N, s, k);
         localparam int LO = (k < P) ? k : P;
         localparam int HI = (k < P) ? P : k;

         logic [WIDTH-1:0] a_lo;
         logic [WIDTH-1:0] a_hi;
         logic             keep;

         if (s == 0) begin : g_src_in
            assign a_lo = bus.data_in[LO*WIDTH +: WIDTH];
            assign a_hi = bus.data_in[HI*WIDTH +: WIDTH];
         end else begin : g_src_q
            assign a_lo = stage_q[s-1][LO];
            assign a_hi = stage_q[s-1][HI];
         end

         // Equal values keep their lanes, so ties never swap.
         if (SIGNED) begin : g_cmp_s
            assign keep = $signed(a_lo) <= $signed(a_hi);
         end else begin : g_cmp_u
            assign keep = a_lo <= a_hi;
         end

         assign stage_d[s][k] = (k == LO) ? (keep ? a_lo : a_hi)
                                          : (keep ? a_hi : a_lo);
      end
   end

   // NOTE: data registers are cleared on reset as well as the valid bits, so bubbles never
   // carry X downstream; all state updates use non-blocking assignment.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int s = 0; s < S; s++) begin
            for (int k = 0; k < N; k++) begin
               stage_q[s][k] <= '0;
            end
         end
      end else if (advance) begin
         valid_q <= (valid_q << 1) | S'(bus.in_valid);
         stage_q <= stage_d;
      end
   end

   assign bus.out_valid = valid_q[S-1];
   for (genvar k = 0; k < N; k++) begin : g_out
      assign bus.sort_out[k*WIDTH +: WIDTH] = stage_q[S-1][k];
   end
   assign bus.median_out = stage_q[S-1][N/2-1];

endmodule

// File: tb/tb_median_sort_pipe.sv
// Scoreboard bench for median_sort_pipe: four instances (N=2, N=4 unsigned, N=4 signed, N=8),
// randomized traffic with backpressure, checked against a plain sort reference model.
module tb_median_sort_pipe;

   localparam int NL [4] = '{2, 4, 4, 8};
   localparam int SL [4] = '{1, 3, 3, 6};
   localparam bit SG [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   logic clk;
   logic rst;

   logic        ival [4];
   logic        ordy [4];
   logic [63:0] din  [4];

   logic        ov   [4];
   logic        ir   [4];
   logic [63:0] so   [4];
   logic [7:0]  med  [4];

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] exp_q [4][$];
   logic        hold_v [4];
   logic [63:0] held   [4];
   logic [63:0] dir_v  [4];
   logic [63:0] dir_e  [4];

   median_sort_pipe_if #(.WIDTH(8), .N(2)) b0 ();
   median_sort_pipe_if #(.WIDTH(8), .N(4)) b1 ();
   median_sort_pipe_if #(.WIDTH(8), .N(4)) b2 ();
   median_sort_pipe_if #(.WIDTH(8), .N(8)) b3 ();

   median_sort_pipe #(.WIDTH(8), .N(2), .SIGNED(1'b0)) u_n2  (.clk(clk), .rst(rst), .bus(b0));
   median_sort_pipe #(.WIDTH(8), .N(4), .SIGNED(1'b0)) u_n4u (.clk(clk), .rst(rst), .bus(b1));
   median_sort_pipe #(.WIDTH(8), .N(4), .SIGNED(1'b1)) u_n4s (.clk(clk), .rst(rst), .bus(b2));
   median_sort_pipe #(.WIDTH(8), .N(8), .SIGNED(1'b0)) u_n8  (.clk(clk), .rst(rst), .bus(b3));

   assign b0.in_valid = ival[0];  assign b0.data_in = din[0][15:0];  assign b0.out_ready = ordy[0];
   assign b1.in_valid = ival[1];  assign b1.data_in = din[1][31:0];  assign b1.out_ready = ordy[1];
   assign b2.in_valid = ival[2];  assign b2.data_in = din[2][31:0];  assign b2.out_ready = ordy[2];
   assign b3.in_valid = ival[3];  assign b3.data_in = din[3];        assign b3.out_ready = ordy[3];

   assign ov[0] = b0.out_valid;  assign ir[0] = b0.in_ready;
   assign ov[1] = b1.out_valid;  assign ir[1] = b1.in_ready;
   assign ov[2] = b2.out_valid;  assign ir[2] = b2.in_ready;
   assign ov[3] = b3.out_valid;  assign ir[3] = b3.in_ready;
   assign so[0] = {48'h0, b0.sort_out};  assign med[0] = b0.median_out;
   assign so[1] = {32'h0, b1.sort_out};  assign med[1] = b1.median_out;
   assign so[2] = {32'h0, b2.sort_out};  assign med[2] = b2.median_out;
   assign so[3] = b3.sort_out;           assign med[3] = b3.median_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int id, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d(N=%0d,signed=%0d): got %h expected %h",
                  name, id, NL[id], SG[id], act, exp);
      end
   endtask

   // Reference: interpret lanes as integers, sort ascending with a plain exchange sort.
   function automatic logic [63:0] ref_sort(input logic [63:0] v, input int n, input bit sgn);
      int a [8];
      int t;
      logic [63:0] r;
      for (int k = 0; k < n; k++) begin
         a[k] = sgn ? int'($signed(v[k*8 +: 8])) : int'(v[k*8 +: 8]);
      end
      for (int i = 0; i < n; i++) begin
         for (int j = i + 1; j < n; j++) begin
            if (a[j] < a[i]) begin
               t = a[i];
               a[i] = a[j];
               a[j] = t;
            end
         end
      end
      r = '0;
      for (int k = 0; k < n; k++) r[k*8 +: 8] = a[k][7:0];
      return r;
   endfunction

   function automatic logic [7:0] rand_lane();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h7F;
         3:       return 8'h80;
         4:       return 8'($urandom_range(0, 3));
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [63:0] rand_vec(input int id);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < NL[id]; k++) v[k*8 +: 8] = rand_lane();
      return v;
   endfunction

   // Monitor: the negedge view shows exactly what the next rising edge will transfer.
   always @(negedge clk) begin
      logic [63:0] e;
      for (int id = 0; id < 4; id++) begin
         if (rst) begin
            exp_q[id].delete();
            hold_v[id] = 1'b0;
         end else begin
            check("in_ready_rule", id, 64'(ir[id]), 64'(!ov[id] || ordy[id]));
            if (hold_v[id]) begin
               check("stall_valid", id, 64'(ov[id]), 64'd1);
               check("stall_hold", id, so[id], held[id]);
            end
            if (ov[id] && ordy[id]) begin
               if (exp_q[id].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_output inst%0d: got %h expected none", id, so[id]);
               end else begin
                  e = exp_q[id].pop_front();
                  check("sort", id, so[id], e);
                  check("median", id, 64'(med[id]), 64'(e[(NL[id]/2-1)*8 +: 8]));
               end
            end
            hold_v[id] = ov[id] && !ordy[id];
            held[id]   = so[id];
            if (ival[id] && ir[id]) exp_q[id].push_back(ref_sort(din[id], NL[id], SG[id]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int id = 0; id < 4; id++) begin
         ival[id] = 1'b0;
         ordy[id] = 1'b1;
      end
      repeat (n) tick();
   endtask

   task automatic random_phase(input int n, input int pv, input int pr);
      for (int c = 0; c < n; c++) begin
         for (int id = 0; id < 4; id++) begin
            din[id]  = rand_vec(id);
            ival[id] = ($urandom_range(0, 99) < pv);
            ordy[id] = ($urandom_range(0, 99) < pr);
         end
         tick();
      end
   endtask

   // One beat into empty pipes; check latency S and the sorted values given in dir_e.
   task automatic directed();
      int seen [4];
      for (int id = 0; id < 4; id++) begin
         din[id]  = dir_v[id];
         ival[id] = 1'b1;
         ordy[id] = 1'b1;
         seen[id] = 0;
      end
      tick();
      for (int id = 0; id < 4; id++) ival[id] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         for (int id = 0; id < 4; id++) begin
            if (seen[id] == 0 && ov[id]) begin
               seen[id] = c;
               check("latency", id, 64'(c), 64'(SL[id]));
               check("dir_sort", id, so[id], dir_e[id]);
               check("dir_median", id, 64'(med[id]), 64'(dir_e[id][(NL[id]/2-1)*8 +: 8]));
            end
         end
      end
      for (int id = 0; id < 4; id++) begin
         if (seen[id] == 0) check("latency_timeout", id, 64'd0, 64'(SL[id]));
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      for (int id = 0; id < 4; id++) begin
         ival[id]   = 1'b0;
         ordy[id]   = 1'b0;
         din[id]    = '0;
         hold_v[id] = 1'b0;
         held[id]   = '0;
      end
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      for (int id = 0; id < 4; id++) begin
         check("rst_out_valid", id, 64'(ov[id]), 64'd0);
         check("rst_sort_out", id, so[id], 64'd0);
         check("rst_median", id, 64'(med[id]), 64'd0);
         check("rst_in_ready", id, 64'(ir[id]), 64'd1);
      end
      tick();

      // {9,2}; {3,1,4,1}; signed {7F,80,FF,00}; {7,6,5,4,3,2,1,0}
      dir_v[0] = 64'h0209;              dir_e[0] = 64'h0902;
      dir_v[1] = 64'h01040103;          dir_e[1] = 64'h04030101;
      dir_v[2] = 64'h00FF807F;          dir_e[2] = 64'h7F00FF80;
      dir_v[3] = 64'h0001020304050607;  dir_e[3] = 64'h0706050403020100;
      directed();
      idle(8);
      // Ties; unsigned {7F,80,FF,00}; signed {3,1,4,1}; mixed extremes with duplicates.
      dir_v[0] = 64'h0505;              dir_e[0] = 64'h0505;
      dir_v[1] = 64'h00FF807F;          dir_e[1] = 64'hFF807F00;
      dir_v[2] = 64'h01040103;          dir_e[2] = 64'h04030101;
      dir_v[3] = 64'h7F800101FF00FF00;  dir_e[3] = 64'hFFFF807F01010000;
      directed();
      idle(8);

      // Back-to-back streaming: after the fill, one output every cycle.
      for (int i = 0; i < 100; i++) begin
         for (int id = 0; id < 4; id++) begin
            din[id]  = rand_vec(id);
            ival[id] = 1'b1;
            ordy[id] = 1'b1;
         end
         @(negedge clk);
         for (int id = 0; id < 4; id++) begin
            if (i >= SL[id]) check("stream_no_gap", id, 64'(ov[id]), 64'd1);
         end
         tick();
      end
      idle(10);

      // Five-cycle output stall on a full pipe.
      for (int c = 0; c < 10; c++) begin
         for (int id = 0; id < 4; id++) begin
            din[id]  = rand_vec(id);
            ival[id] = 1'b1;
            ordy[id] = 1'b1;
         end
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         for (int id = 0; id < 4; id++) begin
            din[id]  = rand_vec(id);
            ordy[id] = 1'b0;
         end
         @(negedge clk);
         for (int id = 0; id < 4; id++) begin
            check("bp_out_valid", id, 64'(ov[id]), 64'd1);
            check("bp_in_ready", id, 64'(ir[id]), 64'd0);
         end
         tick();
      end
      random_phase(300, 70, 60);
      idle(10);

      // Fill with six vectors, then reset while a seventh is presented.
      for (int c = 0; c < 6; c++) begin
         for (int id = 0; id < 4; id++) begin
            din[id]  = rand_vec(id);
            ival[id] = 1'b1;
            ordy[id] = 1'b0;
         end
         tick();
      end
      rst = 1'b1;
      for (int id = 0; id < 4; id++) din[id] = rand_vec(id);
      @(negedge clk);
      check("fill_full", 3, 64'(ov[3]), 64'd1);
      tick();
      rst = 1'b0;
      for (int id = 0; id < 4; id++) begin
         ival[id] = 1'b0;
         ordy[id] = 1'b1;
      end
      @(negedge clk);
      for (int id = 0; id < 4; id++) begin
         check("midrst_out_valid", id, 64'(ov[id]), 64'd0);
         check("midrst_sort_out", id, so[id], 64'd0);
         check("midrst_median", id, 64'(med[id]), 64'd0);
         check("midrst_in_ready", id, 64'(ir[id]), 64'd1);
      end
      tick();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int id = 0; id < 4; id++) check("midrst_no_emerge", id, 64'(ov[id]), 64'd0);
         tick();
      end

      random_phase(200, 80, 75);
      idle(12);
      for (int id = 0; id < 4; id++) check("drain_empty", id, 64'(exp_q[id].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
